// File: rtl/sm3_pad_1024.sv
// sm3_pad_1024: SM3 padding front end for a two-block (1024-bit) compression engine.
// Collects a byte-granular message as 32-bit big-endian words, appends the 0x80
// marker, zero fill and the 64-bit bit length, and presents the padded message on
// dataout with a one-cycle start pulse. Messages that do not pad to exactly two
// blocks are rejected with a one-cycle err pulse.
//
// Ports:
//   clk, rst            rising-edge clock, asynchronous active-high reset
//   din[31:0]           message word, first byte in din[31:24]
//   din_valid           din qualifier
//   din_last            final word of the message
//   din_bytes[1:0]      valid MSB-aligned bytes in the final word (0 means 4)
//   din_ready           word accepted when din_valid && din_ready
//   dataout[1023:0]     padded message, word 0 at [1023:992]
//   start               one-cycle pulse to the engine, dataout valid in the same cycle
//   hash_valid          engine done pulse, releases the block back to loading
//   err                 one-cycle pulse, message length out of range
module sm3_pad_1024 #(
  parameter int unsigned MIN_BYTES = 56,
  parameter int unsigned MAX_BYTES = 119
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [31:0]   din,
  input  logic          din_valid,
  input  logic          din_last,
  input  logic [1:0]    din_bytes,
  output logic          din_ready,
  output logic [1023:0] dataout,
  output logic          start,
  input  logic          hash_valid,
  output logic          err
);

  localparam logic [6:0] MIN_B = 7'(MIN_BYTES);
  localparam logic [6:0] MAX_B = 7'(MAX_BYTES);

  typedef enum logic [2:0] {
    S_LOAD,
    S_CHECK,
    S_PAD,
    S_ISSUE,
    S_WAIT
  } state_t;

  state_t        state, state_n;
  logic [5:0]    word_cnt;
  logic [6:0]    byte_cnt;
  logic [31:0]   buffer [0:29];

  logic          accept;
  logic          len_bad;
  logic          clear;
  logic [2:0]    add_bytes;
  logic [7:0]    byte_sum;
  logic [6:0]    byte_cnt_n;
  logic [31:0]   din_masked;
  logic [9:0]    mark_lsb;
  logic [1023:0] padded;

  assign accept  = din_valid & din_ready;
  assign len_bad = (byte_cnt < MIN_B) || (byte_cnt > MAX_B);
  assign clear   = ((state == S_CHECK) && len_bad) || ((state == S_WAIT) && hash_valid);

  // Byte count of the incoming word; the running total saturates at 127 so that
  // any overlong message still reads as out of range.
  always_comb begin
    add_bytes = 3'd4;
    if (din_last && (din_bytes != 2'd0)) add_bytes = {1'b0, din_bytes};
    byte_sum   = {1'b0, byte_cnt} + {5'b0, add_bytes};
    byte_cnt_n = byte_sum[7] ? 7'd127 : byte_sum[6:0];
  end

  // Invalid trailing bytes of the last word are zeroed so the marker byte
  // position is clean and the zero fill needs no extra masking.
  always_comb begin
    din_masked = din;
    if (din_last) begin
      case (din_bytes)
        2'd1:    din_masked = {din[31:24], 24'h0};
        2'd2:    din_masked = {din[31:16], 16'h0};
        2'd3:    din_masked = {din[31:8], 8'h0};
        default: din_masked = din;
      endcase
    end
  end

  // Padded image: stored words, marker at byte byte_cnt, bit length in words 30..31.
  // Unwritten buffer words are already zero, which provides the zero fill.
  always_comb begin
    padded = '0;
    for (int unsigned i = 0; i < 30; i++) begin
      padded[1023 - 32*i -: 32] = buffer[i];
    end
    mark_lsb = 10'd1016 - {byte_cnt, 3'b000};
    padded[mark_lsb +: 8] = 8'h80;
    padded[63:0] = {54'h0, byte_cnt, 3'b000};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_LOAD;
    else     state <= state_n;
  end

  always_comb begin
    state_n   = state;
    din_ready = 1'b0;
    start     = 1'b0;
    err       = 1'b0;
    case (state)
      S_LOAD: begin
        din_ready = ~rst;
        if (din_valid && din_last) state_n = S_CHECK;
      end
      S_CHECK: begin
        if (len_bad) begin
          err     = 1'b1;
          state_n = S_LOAD;
        end else begin
          state_n = S_PAD;
        end
      end
      S_PAD:   state_n = S_ISSUE;
      S_ISSUE: begin
        start   = 1'b1;
        state_n = S_WAIT;
      end
      S_WAIT: begin
        if (hash_valid) state_n = S_LOAD;
      end
      default: state_n = S_LOAD;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      word_cnt <= '0;
      byte_cnt <= '0;
      dataout  <= '0;
      for (int unsigned i = 0; i < 30; i++) buffer[i] <= '0;
    end else begin
      if (accept) begin
        // Words past index 29 are counted but dropped; the length check rejects them.
        if (word_cnt < 6'd30) buffer[word_cnt[4:0]] <= din_masked;
        if (word_cnt != '1)   word_cnt <= word_cnt + 6'd1;
        byte_cnt <= byte_cnt_n;
      end
      if (state == S_PAD) dataout <= padded;
      if (clear) begin
        word_cnt <= '0;
        byte_cnt <= '0;
        for (int unsigned i = 0; i < 30; i++) buffer[i] <= '0;
      end
    end
  end

endmodule

// File: tb/tb_sm3_pad_1024.sv
module tb_sm3_pad_1024;

  logic          clk = 1'b0;
  logic          rst;
  logic [31:0]   din;
  logic          din_valid;
  logic          din_last;
  logic [1:0]    din_bytes;
  logic          din_ready;
  logic [1023:0] dataout;
  logic          start;
  logic          hash_valid;
  logic          err;

  int checks = 0;
  int passed = 0;
  int failed = 0;

  logic [7:0]    msg [0:255];
  logic [1023:0] exp_first;

  sm3_pad_1024 #(.MIN_BYTES(56), .MAX_BYTES(119)) dut (
    .clk        (clk),
    .rst        (rst),
    .din        (din),
    .din_valid  (din_valid),
    .din_last   (din_last),
    .din_bytes  (din_bytes),
    .din_ready  (din_ready),
    .dataout    (dataout),
    .start      (start),
    .hash_valid (hash_valid),
    .err        (err)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic check32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_int(input string tag, input int obs, input int exp);
    checks++;
    assert (obs == exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic check_vec(input string tag, input logic [1023:0] obs, input logic [1023:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] word_of(input int i);
    logic [1023:0] v;
    v = dataout;
    return v[1023 - 32*i -: 32];
  endfunction

  // Message bytes below len: 0x61 or random; bytes at/after len are random garbage
  // that the padder must never let through.
  task automatic fill_msg(input int len, input bit rnd);
    for (int i = 0; i < 256; i++) begin
      if (i < len && !rnd) msg[i] = 8'h61;
      else                 msg[i] = 8'($urandom);
    end
  endtask

  // Reference: byte-level SM3 padding into a 128-byte array, then packed MSB first.
  function automatic logic [1023:0] model(input int len);
    logic [7:0]    p [0:127];
    logic [63:0]   bits;
    logic [1023:0] v;
    for (int i = 0; i < 128; i++) p[i] = 8'h00;
    for (int i = 0; i < len; i++) p[i] = msg[i];
    p[len] = 8'h80;
    bits = 64'(len) * 64'd8;
    for (int i = 0; i < 8; i++) p[120 + i] = bits[63 - 8*i -: 8];
    v = '0;
    for (int i = 0; i < 128; i++) v = {v[1015:0], p[i]};
    return v;
  endfunction

  task automatic drive_words(input int len, input int upto, output int stalls);
    int nw;
    nw = (len + 3) / 4;
    stalls = 0;
    for (int w = 0; w < nw && w < upto; w++) begin
      if ($urandom_range(0, 3) == 0) begin
        din_valid = 1'b0;
        din       = $urandom;
        din_last  = 1'($urandom);
        din_bytes = 2'($urandom);
        step();
      end
      din       = {msg[4*w], msg[4*w+1], msg[4*w+2], msg[4*w+3]};
      din_valid = 1'b1;
      din_last  = (w == nw - 1);
      din_bytes = (w == nw - 1) ? 2'(len % 4) : 2'($urandom);
      if (din_ready !== 1'b1) stalls++;
      step();
    end
    din_valid = 1'b0;
    din_last  = 1'b0;
  endtask

  task automatic run_msg(input int len, input bit hold_valid, input bit release_eng, input string tag);
    logic [1023:0] exp;
    bit            rej;
    int            stalls;
    int            bad;
    int            n;
    rej = (len < 56) || (len > 119);
    exp = rej ? '0 : model(len);
    drive_words(len, 1000, stalls);
    check_int({tag, "_no_stall"}, stalls, 0);
    din_valid = hold_valid;
    din       = $urandom;
    // cycle after last word: length check
    check1({tag, "_err_check"}, err, rej);
    check1({tag, "_start_c1"}, start, 1'b0);
    check1({tag, "_ready_c1"}, din_ready, 1'b0);
    step();
    if (rej) begin
      check1({tag, "_ready_after_err"}, din_ready, 1'b1);
      check1({tag, "_err_once"}, err, 1'b0);
      check1({tag, "_no_start"}, start, 1'b0);
      return;
    end
    check1({tag, "_start_c2"}, start, 1'b0);
    step();
    check1({tag, "_start_c3"}, start, 1'b1);
    check_vec({tag, "_dataout"}, dataout, exp);
    step();
    check1({tag, "_start_once"}, start, 1'b0);
    n = hold_valid ? 100 : int'($urandom_range(2, 8));
    bad = 0;
    for (int i = 0; i < n; i++) begin
      din = $urandom;
      if (din_ready !== 1'b0 || dataout !== exp || start !== 1'b0 || err !== 1'b0) bad++;
      step();
    end
    check_int({tag, "_wait_hold"}, bad, 0);
    din_valid = 1'b0;
    if (!release_eng) return;
    hash_valid = 1'b1;
    step();
    hash_valid = 1'b0;
    check1({tag, "_ready_after_hash"}, din_ready, 1'b1);
    check_vec({tag, "_dataout_kept"}, dataout, exp);
  endtask

  initial begin
    int stalls;
    rst        = 1'b1;
    din        = '0;
    din_valid  = 1'b0;
    din_last   = 1'b0;
    din_bytes  = '0;
    hash_valid = 1'b0;
    step();
    step();
    check1("reset_ready", din_ready, 1'b0);
    check_vec("reset_dataout", dataout, '0);
    check1("reset_start", start, 1'b0);
    check1("reset_err", err, 1'b0);
    rst = 1'b0;
    #1;
    check1("ready_after_reset", din_ready, 1'b1);
    step();

    // 64 bytes of 'a'
    fill_msg(64, 1'b0);
    exp_first = model(64);
    run_msg(64, 1'b0, 1'b1, "a64");
    check32("a64_w0", word_of(0), 32'h61616161);
    check32("a64_w15", word_of(15), 32'h61616161);
    check32("a64_w16", word_of(16), 32'h80000000);
    check32("a64_w30", word_of(30), 32'h00000000);
    check32("a64_w31", word_of(31), 32'h00000200);

    // 119 bytes of 'a': marker in last byte of word 29
    fill_msg(119, 1'b0);
    run_msg(119, 1'b0, 1'b1, "a119");
    check32("a119_w29", word_of(29), 32'h61616180);
    check32("a119_w30", word_of(30), 32'h00000000);
    check32("a119_w31", word_of(31), 32'h000003B8);

    // minimum length
    fill_msg(56, 1'b1);
    run_msg(56, 1'b0, 1'b1, "r56");
    check32("r56_w14", word_of(14), 32'h80000000);
    check32("r56_w31", word_of(31), 32'h000001C0);

    // rejected lengths
    fill_msg(55, 1'b1);
    run_msg(55, 1'b0, 1'b1, "r55");
    fill_msg(120, 1'b1);
    run_msg(120, 1'b0, 1'b1, "r120");
    fill_msg(200, 1'b1);
    run_msg(200, 1'b0, 1'b1, "r200");
    fill_msg(64, 1'b0);
    run_msg(64, 1'b0, 1'b1, "a64_after_rej");

    // din_valid held high through check/pad/issue/wait
    fill_msg(64, 1'b1);
    run_msg(64, 1'b1, 1'b1, "hold");
    fill_msg(64, 1'b0);
    run_msg(64, 1'b0, 1'b1, "a64_after_hold");

    // reset after 10 words, then a fresh 64-byte message
    fill_msg(64, 1'b1);
    drive_words(64, 10, stalls);
    check_int("abort_no_stall", stalls, 0);
    rst = 1'b1;
    #1;
    check_vec("midmsg_rst_dataout", dataout, '0);
    check1("midmsg_rst_ready", din_ready, 1'b0);
    step();
    rst = 1'b0;
    step();
    fill_msg(64, 1'b0);
    run_msg(64, 1'b0, 1'b1, "a64_after_rst");
    check_vec("a64_after_rst_same", dataout, exp_first);

    // reset while waiting for the engine; its late hash_valid is ignored
    fill_msg(70, 1'b1);
    run_msg(70, 1'b0, 1'b0, "r70_norel");
    rst = 1'b1;
    #1;
    check_vec("midwait_rst_dataout", dataout, '0);
    step();
    rst = 1'b0;
    step();
    hash_valid = 1'b1;
    step();
    hash_valid = 1'b0;
    check1("stale_hash_ready", din_ready, 1'b1);
    check1("stale_hash_start", start, 1'b0);
    check1("stale_hash_err", err, 1'b0);
    fill_msg(60, 1'b1);
    run_msg(60, 1'b0, 1'b1, "r60");

    // random lengths around both boundaries
    for (int k = 0; k < 10; k++) begin
      int len;
      len = int'($urandom_range(40, 140));
      fill_msg(len, 1'b1);
      run_msg(len, 1'b0, 1'b1, $sformatf("rand%0d_len%0d", k, len));
    end

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
